bp_be_idiv_early: RTL and testbench

Parametrised iterative integer divide unit for the long-latency execution pipe. It is the successor to the fixed single-width `bsg_idiv_iterative` use in that pipe. It adds:
- RV64 word-mode (DIVW/DIVUW/REMW/REMUW) handling;
- a configurable 1- or 2-bit-per-cycle radix;
- early exit based on dividend magnitude;
- single-cycle fast paths for divide-by-zero and signed overflow;
- a writeback tag carried alongside the operation.

It sits between the reservation register and the integer writeback arbiter.

---
 rtl/bp_be_idiv_early.sv | 224 ++++++++++++++++++++++
 tb/tb_bp_be_idiv_early.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_idiv_early.sv
// bp_be_idiv_early
//   Iterative restoring integer divider for the long-latency execution pipe.
//   Handles signed/unsigned DIV/REM in full-width and RV64 word mode, retires
//   1 or 2 quotient bits per cycle, trims the iteration count by dividend
//   magnitude, and resolves divide-by-zero / signed overflow in one cycle.
//
// Ports
//   clk_i        clock
//   reset_n_i    asynchronous active-low reset
//   flush_i      synchronous kill of any in-flight or pending operation
//   v_i          request valid
//   ready_and_o  unit idle and able to accept (state decode)
//   dividend_i   rs1
//   divisor_i    rs2
//   signed_i     signed operation
//   rem_i        return remainder instead of quotient
//   word_i       32-bit word operation
//   tag_i        writeback tag, returned with the result
//   v_o          result valid (state decode)
//   result_o     registered quotient or remainder
//   tag_o        registered tag of the result
//   yumi_i       consumer takes the result
`default_nettype none

module bp_be_idiv_early #(
    parameter int width_p         = 64,
    parameter int bits_per_iter_p = 1,
    parameter int tag_width_p     = 5,
    parameter int early_exit_p    = 1
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   flush_i,
    input  logic                   v_i,
    output logic                   ready_and_o,
    input  logic [width_p-1:0]     dividend_i,
    input  logic [width_p-1:0]     divisor_i,
    input  logic                   signed_i,
    input  logic                   rem_i,
    input  logic                   word_i,
    input  logic [tag_width_p-1:0] tag_i,
    output logic                   v_o,
    output logic [width_p-1:0]     result_o,
    output logic [tag_width_p-1:0] tag_o,
    input  logic                   yumi_i
);

    localparam int cnt_w = $clog2(width_p + 1);

    typedef enum logic [1:0] {
        e_idle,
        e_calc,
        e_adj,
        e_done
    } state_e;

    state_e             state_r;
    logic [cnt_w-1:0]   cnt_r;

    logic [width_p-1:0] rem_r;
    logic [width_p-1:0] quo_r;
    logic [width_p-1:0] dvs_r;
    logic               neg_q_r;
    logic               neg_r_r;
    logic               rem_sel_r;
    logic               word_r;

    // Word-mode operand extension from the low 32 bits.
    function automatic logic [width_p-1:0] extend_op(input logic [width_p-1:0] x,
                                                     input logic is_signed,
                                                     input logic is_word);
        if (!is_word)
            return x;
        return is_signed ? {{(width_p-32){x[31]}}, x[31:0]}
                         : {{(width_p-32){1'b0}}, x[31:0]};
    endfunction

    function automatic logic [width_p-1:0] abs_mag(input logic signed [width_p-1:0] x,
                                                   input logic is_signed);
        logic signed [width_p-1:0] neg;
        neg = -x;
        return (is_signed && x[width_p-1]) ? neg : x;
    endfunction

    // Word results are always the low 32 bits sign-extended, unsigned ops too.
    function automatic logic [width_p-1:0] word_fix(input logic [width_p-1:0] x,
                                                    input logic is_word);
        return is_word ? {{(width_p-32){x[31]}}, x[31:0]} : x;
    endfunction

    // Number of significant bits (position of the highest one plus one).
    // Word-mode magnitudes have zero upper bits, so this also equals
    // ew - clz_ew for 32-bit operations.
    function automatic logic [cnt_w-1:0] sig_bits(input logic [width_p-1:0] x);
        logic [cnt_w-1:0] s;
        s = '0;
        for (int i = 0; i < width_p; i++)
            if (x[i])
                s = cnt_w'(i + 1);
        return s;
    endfunction

    logic               accept;
    logic [width_p-1:0] a_ext, b_ext, a_mag, b_mag, a_shift;
    logic [width_p-1:0] min_val;
    logic               a_neg, b_neg;
    logic               div_zero, ovf, special;
    logic [width_p-1:0] spec_res;
    logic [cnt_w-1:0]   sig_v, n_iter, steps;

    assign ready_and_o = (state_r == e_idle);
    assign v_o         = (state_r == e_done);
    assign accept      = v_i & ready_and_o & ~flush_i;

    assign a_ext    = extend_op(dividend_i, signed_i, word_i);
    assign b_ext    = extend_op(divisor_i, signed_i, word_i);
    assign a_neg    = signed_i & a_ext[width_p-1];
    assign b_neg    = signed_i & b_ext[width_p-1];
    assign a_mag    = abs_mag(a_ext, signed_i);
    assign b_mag    = abs_mag(b_ext, signed_i);
    assign min_val  = word_i ? {{(width_p-31){1'b1}}, 31'b0} : {1'b1, {(width_p-1){1'b0}}};
    assign div_zero = (b_ext == '0);
    assign ovf      = signed_i & (a_ext == min_val) & (b_ext == '1);
    assign special  = div_zero | ovf;
    assign spec_res = word_fix(div_zero ? (rem_i ? a_ext : '1) : (rem_i ? '0 : a_ext), word_i);

    always_comb begin
        sig_v = sig_bits(a_mag);
        if (sig_v == '0)
            sig_v = cnt_w'(1);
        if (early_exit_p == 0)
            sig_v = word_i ? cnt_w'(32) : cnt_w'(width_p);
        n_iter = (bits_per_iter_p == 2) ? ((sig_v + cnt_w'(1)) >> 1) : sig_v;
        steps  = (bits_per_iter_p == 2) ? {n_iter[cnt_w-2:0], 1'b0} : n_iter;
        // Left-align the significant bits at the top of the full register;
        // word operands sit in the low half, so this matches ew-based alignment.
        a_shift = a_mag << (cnt_w'(width_p) - steps);
    end

    logic [width_p-1:0] rem_nxt, quo_nxt;
    logic [width_p:0]   shifted;

    always_comb begin
        rem_nxt = rem_r;
        quo_nxt = quo_r;
        shifted = '0;
        for (int k = 0; k < bits_per_iter_p; k++) begin
            shifted = {rem_nxt, quo_nxt[width_p-1]};
            if (shifted >= {1'b0, dvs_r}) begin
                rem_nxt = shifted[width_p-1:0] - dvs_r;
                quo_nxt = {quo_nxt[width_p-2:0], 1'b1};
            end else begin
                rem_nxt = shifted[width_p-1:0];
                quo_nxt = {quo_nxt[width_p-2:0], 1'b0};
            end
        end
    end

    logic [width_p-1:0] q_fix, r_fix, adj_res;

    assign q_fix   = neg_q_r ? (-quo_r) : quo_r;
    assign r_fix   = neg_r_r ? (-rem_r) : rem_r;
    assign adj_res = word_fix(rem_sel_r ? r_fix : q_fix, word_r);

    // ---- operand / iteration registers (no reset: qualified by state) ----
    always_ff @(posedge clk_i) begin
        if (accept) begin
            rem_r     <= '0;
            quo_r     <= a_shift;
            dvs_r     <= b_mag;
            neg_q_r   <= a_neg ^ b_neg;
            neg_r_r   <= a_neg;
            rem_sel_r <= rem_i;
            word_r    <= word_i;
        end else if (state_r == e_calc) begin
            rem_r <= rem_nxt;
            quo_r <= quo_nxt;
        end
    end

    // ---- control FSM and registered outputs ----
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r  <= e_idle;
            cnt_r    <= '0;
            result_o <= '0;
            tag_o    <= '0;
        end else if (flush_i) begin
            state_r <= e_idle;
        end else begin
            case (state_r)
                e_idle: begin
                    if (v_i) begin
                        tag_o <= tag_i;
                        if (special) begin
                            result_o <= spec_res;
                            state_r  <= e_done;
                        end else begin
                            cnt_r   <= n_iter;
                            state_r <= e_calc;
                        end
                    end
                end
                e_calc: begin
                    cnt_r <= cnt_r - cnt_w'(1);
                    if (cnt_r == cnt_w'(1))
                        state_r <= e_adj;
                end
                e_adj: begin
                    result_o <= adj_res;
                    state_r  <= e_done;
                end
                e_done: begin
                    if (yumi_i)
                        state_r <= e_idle;
                end
                default: state_r <= e_idle;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bp_be_idiv_early.sv
// Testbench for bp_be_idiv_early: two instances (1 and 2 bits per cycle) are
// driven with the same requests and compared against a plain-arithmetic
// reference model for result, tag and latency.
`timescale 1ns/1ps

module tb_bp_be_idiv_early;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, flush, v_in, sgn, rem, word, yumi;
    logic [63:0] dividend, divisor;
    logic [4:0]  tag;

    logic        rdy1, vo1, rdy2, vo2;
    logic [63:0] res1, res2;
    logic [4:0]  tag1, tag2;

    int n_checks = 0;
    int n_fail   = 0;

    bp_be_idiv_early #(.width_p(64), .bits_per_iter_p(1), .tag_width_p(5), .early_exit_p(1)) u_dut1 (
        .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush), .v_i(v_in), .ready_and_o(rdy1),
        .dividend_i(dividend), .divisor_i(divisor), .signed_i(sgn), .rem_i(rem), .word_i(word),
        .tag_i(tag), .v_o(vo1), .result_o(res1), .tag_o(tag1), .yumi_i(yumi));

    bp_be_idiv_early #(.width_p(64), .bits_per_iter_p(2), .tag_width_p(5), .early_exit_p(1)) u_dut2 (
        .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush), .v_i(v_in), .ready_and_o(rdy2),
        .dividend_i(dividend), .divisor_i(divisor), .signed_i(sgn), .rem_i(rem), .word_i(word),
        .tag_i(tag), .v_o(vo2), .result_o(res2), .tag_o(tag2), .yumi_i(yumi));

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h required %h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] ext64(input logic [63:0] x, input logic s, input logic w);
        if (!w) return x;
        return s ? {{32{x[31]}}, x[31:0]} : {32'h0, x[31:0]};
    endfunction

    function automatic bit is_special(input logic [63:0] a, b, input logic s, w);
        if (w) return (b[31:0] == 32'h0) ||
                      (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        return (b == 64'h0) || (s && a == 64'h8000_0000_0000_0000 && b == '1);
    endfunction

    // Bits needed to represent |dividend| (minimum 1).
    function automatic int sig_of(input logic [63:0] a, input logic s, input logic w);
        logic [63:0] ae, mag;
        int n;
        ae  = ext64(a, s, w);
        mag = (s && ae[63]) ? (~ae + 64'd1) : ae;
        n = 1;
        while (n < 64 && (mag >> n) != 64'h0) n++;
        return n;
    endfunction

    function automatic logic [63:0] model(input logic [63:0] a, b, input logic s, r, w);
        logic [31:0] a32, b32, q32, r32, p32;
        logic [63:0] q, rm;
        longint      sa, sb;
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 32'h0) begin
                q32 = '1; r32 = a32;
            end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32; r32 = 32'h0;
            end else if (s) begin
                q32 = $signed(a32) / $signed(b32);
                r32 = $signed(a32) % $signed(b32);
            end else begin
                q32 = a32 / b32;
                r32 = a32 % b32;
            end
            p32 = r ? r32 : q32;
            return {{32{p32[31]}}, p32};
        end
        if (b == 64'h0) begin
            q = '1; rm = a;
        end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
            q = a; rm = 64'h0;
        end else if (s) begin
            sa = a; sb = b;
            q  = sa / sb;
            rm = sa % sb;
        end else begin
            q  = a / b;
            rm = a % b;
        end
        return r ? rm : q;
    endfunction

    task automatic do_op(input logic [63:0] a, b, input logic s, r, w,
                         input logic [4:0] t, input int hold);
        logic [63:0] exp;
        int e1, e2, l1, l2, c, sg;
        exp = model(a, b, s, r, w);
        if (is_special(a, b, s, w)) begin
            e1 = 1; e2 = 1;
        end else begin
            sg = sig_of(a, s, w);
            e1 = sg + 2;
            e2 = (sg + 1) / 2 + 2;
        end
        @(negedge clk);
        v_in = 1'b1; dividend = a; divisor = b; sgn = s; rem = r; word = w; tag = t;
        @(posedge clk);
        #1;
        v_in = 1'b0;
        dividend = {$urandom, $urandom}; divisor = {$urandom, $urandom};
        sgn = ~s; rem = ~r; word = ~w; tag = ~t;
        l1 = 0; l2 = 0; c = 1;
        while ((l1 == 0 || l2 == 0) && c < 100) begin
            @(negedge clk);
            if (vo1 && l1 == 0) l1 = c;
            if (vo2 && l2 == 0) l2 = c;
            if (l1 == 0 || l2 == 0) begin
                @(posedge clk);
                c++;
            end
        end
        chk("latency_bpi1", 64'(l1), 64'(e1));
        chk("latency_bpi2", 64'(l2), 64'(e2));
        chk("result_bpi1", res1, exp);
        chk("result_bpi2", res2, exp);
        chk("tag_bpi1", {59'h0, tag1}, {59'h0, t});
        chk("tag_bpi2", {59'h0, tag2}, {59'h0, t});
        if (hold > 0) begin
            // A competing request while DONE must be ignored.
            v_in = 1'b1; dividend = 64'd77; divisor = 64'd5; tag = t + 5'd1;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk("hold_v", {63'h0, vo1 & vo2}, 64'h1);
                chk("hold_result", res1, exp);
                chk("hold_tag", {59'h0, tag1}, {59'h0, t});
            end
            v_in = 1'b0;
        end
        yumi = 1'b1;
        @(posedge clk);
        #1;
        yumi = 1'b0;
        chk("ready_after_yumi", {63'h0, rdy1 & rdy2}, 64'h1);
        chk("v_after_yumi", {63'h0, vo1 | vo2}, 64'h0);
    endtask

    function automatic logic [63:0] rnd64();
        logic [63:0] x;
        x = {$urandom, $urandom};
        return x >> $urandom_range(0, 63);
    endfunction

    initial begin
        logic [63:0] a, b;
        bit seen;
        reset_n = 1'b0; flush = 1'b0; v_in = 1'b0; sgn = 1'b0; rem = 1'b0; word = 1'b0;
        yumi = 1'b0; dividend = '0; divisor = '0; tag = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", {63'h0, rdy1 & rdy2}, 64'h1);
        chk("reset_v", {63'h0, vo1 | vo2}, 64'h0);
        chk("reset_result", res1 | res2, 64'h0);
        chk("reset_tag", {59'h0, tag1 | tag2}, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;

        do_op(64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 5'd1, 0);
        do_op(64'd100, 64'd7, 1'b0, 1'b1, 1'b0, 5'd2, 0);
        do_op(-64'sd20, 64'd3, 1'b1, 1'b0, 1'b0, 5'd3, 0);
        do_op(-64'sd20, 64'd3, 1'b1, 1'b1, 1'b0, 5'd4, 0);
        do_op(64'd5, 64'd0, 1'b0, 1'b0, 1'b0, 5'd5, 0);
        do_op(64'd5, 64'd0, 1'b0, 1'b1, 1'b0, 5'd6, 0);
        do_op(64'h8000_0000_0000_0000, '1, 1'b1, 1'b0, 1'b0, 5'd7, 0);
        do_op(64'h8000_0000_0000_0000, '1, 1'b1, 1'b1, 1'b0, 5'd8, 0);
        do_op(64'h1_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b1, 5'd9, 0);
        do_op(64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 5'd10, 0);
        do_op(64'd0, 64'd9, 1'b1, 1'b0, 1'b0, 5'd11, 0);

        // Flush during CALC of a long operation.
        @(negedge clk);
        v_in = 1'b1; dividend = 64'hFFFF_0000_1234_5678; divisor = 64'd3;
        sgn = 1'b0; rem = 1'b0; word = 1'b0; tag = 5'd12;
        @(posedge clk);
        #1 v_in = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_v", {63'h0, vo1 | vo2}, 64'h0);
        chk("flush_ready", {63'h0, rdy1 & rdy2}, 64'h1);
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (vo1 | vo2) seen = 1'b1;
        end
        chk("flush_no_v", {63'h0, seen}, 64'h0);
        do_op(64'd9, 64'd3, 1'b0, 1'b0, 1'b0, 5'd13, 0);

        // Flush in the same cycle as a request: the request is dropped.
        @(negedge clk);
        v_in = 1'b1; flush = 1'b1; dividend = 64'd9; divisor = 64'd3; tag = 5'd14;
        @(posedge clk);
        #1;
        v_in = 1'b0; flush = 1'b0;
        chk("flush_drop_ready", {63'h0, rdy1 & rdy2}, 64'h1);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (vo1 | vo2) seen = 1'b1;
        end
        chk("flush_drop_no_v", {63'h0, seen}, 64'h0);

        // Back-pressure in DONE.
        do_op(64'd1000, 64'd10, 1'b0, 1'b0, 1'b0, 5'd15, 5);
        do_op(64'hFFFF_FFFF_FFFF_FF00, 64'd7, 1'b1, 1'b1, 1'b1, 5'd16, 3);

        // Asynchronous reset mid-CALC.
        @(negedge clk);
        v_in = 1'b1; dividend = 64'h7FFF_FFFF_FFFF_FFFF; divisor = 64'd5;
        sgn = 1'b0; rem = 1'b0; word = 1'b0; tag = 5'd17;
        @(posedge clk);
        #1 v_in = 1'b0;
        repeat (4) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("areset_v", {63'h0, vo1 | vo2}, 64'h0);
        chk("areset_ready", {63'h0, rdy1 & rdy2}, 64'h1);
        chk("areset_result", res1 | res2, 64'h0);
        chk("areset_tag", {59'h0, tag1 | tag2}, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        do_op(64'd123456789, 64'd1000, 1'b0, 1'b1, 1'b0, 5'd18, 0);

        // Randomized operations, with edge operands mixed in.
        for (int i = 0; i < 120; i++) begin
            a = rnd64();
            b = rnd64() >> $urandom_range(0, 40);
            case ($urandom_range(0, 9))
                0: b = 64'h0;
                1: b = '1;
                2: a = 64'h8000_0000_0000_0000;
                3: begin a = 64'hFFFF_FFFF_8000_0000 | rnd64(); b = 64'hFFFF_FFFF; end
                4: a = -a;
                5: b = -b;
                default: ;
            endcase
            do_op(a, b, 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
